// File: rtl/alu16_chain_sequencer_if.sv
// rtl/alu16_chain_sequencer_if.sv - request, response and 8-bit ALU bus bundle for the 16-bit chain sequencer
interface alu16_chain_sequencer_if #(
    parameter int OP_W   = 3,
    parameter int BYTE_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [2*BYTE_W-1:0]   req_a;
    logic [2*BYTE_W-1:0]   req_b;
    logic [OP_W-1:0]       req_op;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*BYTE_W-1:0]   rsp_result;
    logic                  rsp_c;
    logic                  rsp_v;
    logic                  rsp_n;
    logic                  rsp_z;

    logic [BYTE_W-1:0]     alu_a;
    logic [BYTE_W-1:0]     alu_b;
    logic [OP_W-1:0]       alu_sel;
    logic [BYTE_W-1:0]     alu_out;
    logic                  alu_cout;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready, alu_out, alu_cout,
        input  req_ready, rsp_valid, rsp_result, rsp_c, rsp_v, rsp_n, rsp_z,
               alu_a, alu_b, alu_sel
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready, alu_out, alu_cout,
        output req_ready, rsp_valid, rsp_result, rsp_c, rsp_v, rsp_n, rsp_z,
               alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu16_chain_sequencer.sv
// rtl/alu16_chain_sequencer.sv - 16-bit ALU ops built from byte passes through an external 8-bit ALU
module alu16_chain_sequencer #(
    parameter int OP_W   = 3,
    parameter int BYTE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu16_chain_sequencer_if.slave bus
);
    localparam int W = 2 * BYTE_W;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_INC  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_PASS = OP_W'(3);

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;

    state_t              r_state;
    logic [W-1:0]        r_a;
    logic [BYTE_W-1:0]   r_b_hi;
    logic [OP_W-1:0]     r_op;
    logic [BYTE_W-1:0]   r_res_lo;
    logic                r_c0;
    logic                r_c1;

    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [W-1:0]        r_rsp_result;
    logic                r_rsp_c;
    logic                r_rsp_v;
    logic                r_rsp_n;
    logic                r_rsp_z;
    logic [BYTE_W-1:0]   r_alu_a;
    logic [BYTE_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_sel;

    logic                w_in_fix;
    logic                w_need_fix;
    logic [W-1:0]        w_res;
    logic                w_c1;
    logic                w_c2;
    logic                w_carry;
    logic                w_ovf;

    // The final high byte always arrives from the ALU in the last pass (HI or FIX).
    assign w_in_fix   = (r_state == S_FIX);
    assign w_res      = {bus.alu_out, r_res_lo};
    assign w_c1       = w_in_fix ? r_c1 : bus.alu_cout;
    assign w_c2       = w_in_fix ? bus.alu_cout : 1'b0;
    assign w_need_fix = ((r_op == OP_ADD) && r_c0) || ((r_op == OP_SUB) && !r_c0);

    always_comb begin
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_carry = w_c1 | w_c2;
                w_ovf   = (r_a[W-1] == r_b_hi[BYTE_W-1]) && (w_res[W-1] != r_a[W-1]);
            end
            OP_SUB: begin
                w_carry = w_c1 & (w_in_fix ? w_c2 : 1'b1);
                w_ovf   = (r_a[W-1] != r_b_hi[BYTE_W-1]) && (w_res[W-1] != r_a[W-1]);
            end
            OP_INC: begin
                w_carry = r_c0 & w_c1;
                w_ovf   = (r_a == {1'b0, {(W-1){1'b1}}});
            end
            default: begin
                w_carry = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    // ALU drive registers are loaded on the edge entering each pass state so the pass lasts one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b_hi       <= '0;
            r_op         <= '0;
            r_res_lo     <= '0;
            r_c0         <= 1'b0;
            r_c1         <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_c      <= 1'b0;
            r_rsp_v      <= 1'b0;
            r_rsp_n      <= 1'b0;
            r_rsp_z      <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_a         <= bus.req_a;
                        r_b_hi      <= bus.req_b[W-1:BYTE_W];
                        r_op        <= bus.req_op;
                        r_req_ready <= 1'b0;
                        r_alu_a     <= bus.req_a[BYTE_W-1:0];
                        r_alu_b     <= bus.req_b[BYTE_W-1:0];
                        r_alu_sel   <= bus.req_op;
                        r_state     <= S_LO;
                    end
                end
                S_LO: begin
                    r_res_lo  <= bus.alu_out;
                    r_c0      <= bus.alu_cout;
                    r_alu_a   <= r_a[W-1:BYTE_W];
                    r_alu_b   <= r_b_hi;
                    r_alu_sel <= ((r_op == OP_INC) && !bus.alu_cout) ? OP_PASS : r_op;
                    r_state   <= S_HI;
                end
                S_HI, S_FIX: begin
                    if ((r_state == S_HI) && w_need_fix) begin
                        // No carry-in on the ALU: propagate the low-byte carry/borrow with a second high pass.
                        r_c1      <= bus.alu_cout;
                        r_alu_a   <= bus.alu_out;
                        r_alu_b   <= (r_op == OP_SUB) ? {BYTE_W{1'b1}} : '0;
                        r_alu_sel <= (r_op == OP_SUB) ? OP_ADD : OP_INC;
                        r_state   <= S_FIX;
                    end else begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= w_res;
                        r_rsp_c      <= w_carry;
                        r_rsp_v      <= w_ovf;
                        r_rsp_n      <= w_res[W-1];
                        r_rsp_z      <= (w_res == '0);
                        r_alu_a      <= '0;
                        r_alu_b      <= '0;
                        r_alu_sel    <= '0;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_alu_a     <= '0;
                    r_alu_b     <= '0;
                    r_alu_sel   <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_c      = r_rsp_c;
    assign bus.rsp_v      = r_rsp_v;
    assign bus.rsp_n      = r_rsp_n;
    assign bus.rsp_z      = r_rsp_z;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_sel    = r_alu_sel;
endmodule

// File: tb/tb_alu16_chain_sequencer.sv
// tb/tb_alu16_chain_sequencer.sv - scoreboard bench for the 16-bit chain sequencer with a behavioural 8-bit ALU
module tb_alu16_chain_sequencer;
    logic clk;
    logic rst_n;

    alu16_chain_sequencer_if #(.OP_W(3), .BYTE_W(8)) bus ();

    alu16_chain_sequencer #(.OP_W(3), .BYTE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] alu_t;
    logic       alu_c;
    always_comb begin
        alu_t = 9'd0;
        alu_c = 1'b0;
        case (bus.alu_sel)
            3'd0: begin alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b}; alu_c = alu_t[8]; end
            3'd1: begin alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b}; alu_c = (bus.alu_a >= bus.alu_b); end
            3'd2: begin alu_t = {1'b0, bus.alu_a} + 9'd1; alu_c = alu_t[8]; end
            3'd3: alu_t = {1'b0, bus.alu_a};
            3'd4: alu_t = {1'b0, bus.alu_a & bus.alu_b};
            3'd5: alu_t = {1'b0, bus.alu_a | bus.alu_b};
            3'd6: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
            default: alu_t = {1'b0, ~bus.alu_a};
        endcase
        bus.alu_out  = alu_t[7:0];
        bus.alu_cout = alu_c;
    end

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        v;
        logic        n;
        logic        z;
        logic [3:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        exp_t        e;
        logic [16:0] s;
        logic        fix;
        e   = '0;
        s   = '0;
        fix = 1'b0;
        case (op)
            3'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[15:0];
                e.c = s[16];
                e.v = (a[15] == b[15]) && (e.r[15] != a[15]);
                fix = ({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255;
            end
            3'd1: begin
                e.r = a - b;
                e.c = (a >= b);
                e.v = (a[15] != b[15]) && (e.r[15] != a[15]);
                fix = (a[7:0] < b[7:0]);
            end
            3'd2: begin
                e.r = a + 16'd1;
                e.c = (a == 16'hFFFF);
                e.v = (a == 16'h7FFF);
            end
            3'd3: e.r = a;
            3'd4: e.r = a & b;
            3'd5: e.r = a | b;
            3'd6: e.r = a ^ b;
            default: e.r = ~a;
        endcase
        e.n   = e.r[15];
        e.z   = (e.r == 16'h0000);
        e.lat = fix ? 4'd4 : 4'd3;
        return e;
    endfunction

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op, input int hold);
        exp_t        e;
        int          lat;
        logic [15:0] held;
        sb.push_back(model(a, b, op));
        @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_op    = op;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = 16'($urandom);
        bus.req_b     = 16'($urandom);
        bus.req_op    = 3'($urandom);
        lat = 1;
        while (!bus.rsp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("latency", lat, e.lat);
        chk("result", bus.rsp_result, e.r);
        chk("flags_cvnz", {bus.rsp_c, bus.rsp_v, bus.rsp_n, bus.rsp_z}, {e.c, e.v, e.n, e.z});
        chk("req_ready_busy", bus.req_ready, 0);
        held = bus.rsp_result;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            chk("hold_result", bus.rsp_result, held);
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_clear", bus.rsp_valid, 0);
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp", {bus.rsp_result, bus.rsp_c, bus.rsp_v, bus.rsp_n, bus.rsp_z}, 0);
        chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // rsp_ready with no response pending must be harmless.
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("idle_rsp_ready", bus.rsp_valid, 0);

        do_op(16'h00FF, 16'h0001, 3'd0, 0);
        do_op(16'hFFFF, 16'h0001, 3'd0, 0);
        do_op(16'h7FFF, 16'h0001, 3'd0, 0);
        do_op(16'h0100, 16'h0001, 3'd1, 0);
        do_op(16'h0000, 16'h0001, 3'd1, 0);
        do_op(16'h8000, 16'h0001, 3'd1, 0);
        do_op(16'h7FFF, 16'h1234, 3'd2, 0);
        do_op(16'hFFFF, 16'h0000, 3'd2, 0);
        do_op(16'h12FE, 16'h0000, 3'd2, 0);
        do_op(16'hF0F0, 16'h0FF0, 3'd4, 5);
        do_op(16'h0000, 16'hAAAA, 3'd7, 0);
        do_op(16'hA5C3, 16'h0F0F, 3'd3, 0);

        // Abort an ADD during its HI pass with an asynchronous reset.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 16'h1234;
        bus.req_b     = 16'h00FF;
        bus.req_op    = 3'd0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hi_alu_a", bus.alu_a, 8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", bus.rsp_valid, 0);
        chk("async_req_ready", bus.req_ready, 1);
        chk("async_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h00FF, 16'h0001, 3'd0, 0);

        for (int i = 0; i < 60; i++) begin
            do_op(16'($urandom), 16'($urandom), 3'($urandom), (i % 7 == 0) ? 2 : 0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu16_chain_sequencer.md
Name: alu16_chain_sequencer

Overview:
- Executes 16-bit operations by issuing two or three byte-wide passes to the existing 8-bit combinational ALU.
- The 8-bit ALU has operand inputs A and B, a 3-bit select S, a result Out and a carry C_Out. It has no carry-in, so carry and borrow propagation is resolved here with a correction pass.
- Sits between a requesting controller (valid/ready request channel) and the ALU. Returns a 16-bit result plus C/V/N/Z flags on a valid/ready response channel.

Parameters:
- OP_W, 3, width of the op select (fixed to match the ALU encoding)
- BYTE_W, 8, ALU datapath width; 16-bit operands are 2*BYTE_W

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  sequencer can accept a request
- req_a  input  16  operand A
- req_b  input  16  operand B
- req_op  input  3  op: 000 ADD, 001 SUB, 010 INC(A), 011 PASS(A), 100 AND, 101 OR, 110 XOR, 111 NOT(A)
- rsp_valid  output  1  result registered and held
- rsp_ready  input  1  consumer takes the result
- rsp_result  output  16  result
- rsp_c  output  1  carry out (ADD/INC); not-borrow (SUB); 0 otherwise
- rsp_v  output  1  signed overflow (ADD/SUB/INC); 0 otherwise
- rsp_n  output  1  rsp_result[15]
- rsp_z  output  1  rsp_result == 0
- alu_a  output  8  ALU operand A
- alu_b  output  8  ALU operand B
- alu_sel  output  3  ALU select
- alu_out  input  8  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_cout  input  1  ALU carry (for SUB: 1 = no borrow)

Behaviour:
- Reset (async, rst_n=0): state IDLE, req_ready=1, rsp_valid=0, all rsp_* = 0, alu_a/alu_b/alu_sel = 0. Any in-flight operation is discarded.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch req_a, req_b, req_op and go to LO.
  - LO: drive the low bytes with sel=op. Capture alu_out into res[7:0] and alu_cout into c0. Go to HI.
  - HI: drive the high bytes and capture res[15:8] and c1. Select for this pass:
    - INC: sel=010 if c0=1, else sel=011 (PASS).
    - All other ops: sel=op.
    - Go to FIX if (ADD and c0=1) or (SUB and c0=0); otherwise go to DONE.
  - FIX: ADD drives alu_a=res[15:8], sel=010. SUB drives alu_a=res[15:8], alu_b=8'hFF, sel=000 (decrement). Capture res[15:8] and c2. Go to DONE.
  - DONE: rsp_valid=1; outputs are stable until rsp_ready=1 is sampled. Then go to IDLE and clear rsp_valid.
- alu_a/alu_b/alu_sel are 0 outside LO/HI/FIX.
- The ALU is combinational, so each pass is exactly one cycle. Latency from the accept edge to rsp_valid is 3 cycles without FIX and 4 with FIX.
- req_ready=1 only in IDLE, so the next request is accepted no earlier than the cycle after the response handshake.
- Final carry:
  - ADD: c1 | c2 (c2=0 if FIX not run).
  - SUB: c1 & (FIX ? c2 : 1).
  - INC: c0 & c1.
  - Other ops: 0.
- Overflow is computed from the latched operands and the final result; the ALU overflow output is ignored:
  - ADD: a[15]==b[15] && r[15]!=a[15].
  - SUB: a[15]!=b[15] && r[15]!=a[15].
  - INC: a==16'h7FFF.
  - Other ops: 0.
- N and Z are taken from the final 16-bit result for every op.
- Boundary conditions:
  - req_valid while busy is ignored; the requester holds it.
  - rsp_ready while not rsp_valid has no effect.
  - Changes on req_* after acceptance have no effect.
  - rst_n asserted in any state returns to IDLE immediately, independent of clk.

Test Plan:
- ADD 16'h00FF + 16'h0001 -> FIX runs; result 16'h0100, C=0, V=0, N=0, Z=0; rsp_valid 4 cycles after accept.
- ADD 16'hFFFF + 16'h0001 -> result 16'h0000, C=1, V=0, Z=1. ADD 16'h7FFF + 16'h0001 -> 16'h8000, V=1, N=1.
- SUB 16'h0100 - 16'h0001 -> FIX decrement; 16'h00FF, C=1, V=0. SUB 16'h0000 - 16'h0001 -> 16'hFFFF, C=0, N=1.
- SUB 16'h8000 - 16'h0001 -> 16'h7FFF, V=1. INC 16'h7FFF -> 16'h8000, V=1, C=0. INC 16'hFFFF -> 16'h0000, C=1, Z=1.
- AND 16'hF0F0 & 16'h0FF0 -> 16'h00F0, C=V=0, latency 3. NOT 16'h0000 -> 16'hFFFF, N=1. Hold rsp_ready=0 for 5 cycles: outputs stable and req_ready=0 throughout.
- Assert rst_n=0 during the HI pass of an ADD -> immediately rsp_valid=0, req_ready=1, alu_* = 0. A following request completes correctly. Random 16-bit sweep against a reference model reports zero mismatches.
